// File: rtl/qed_dup_injector_if.sv
// +--------------------------------------------------------------------------+
// | qed_dup_injector_if : instruction-side bus of the SQED duplicate injector |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface qed_dup_injector_if #(
  parameter int PTR_W = 4,
  parameter int CNT_W = 16
);
  logic [31:0]      ifu_qed_instruction;
  logic             exec_dup;
  logic             stall;
  logic [31:0]      qed_ifu_instruction;
  logic             qed_vld_out;
  logic [PTR_W:0]   qed_fifo_count;
  logic             qed_drained;
  logic [CNT_W-1:0] orig_issued;
  logic [CNT_W-1:0] dup_issued;

  modport master (
    output ifu_qed_instruction, exec_dup, stall,
    input  qed_ifu_instruction, qed_vld_out, qed_fifo_count, qed_drained,
           orig_issued, dup_issued
  );

  modport slave (
    input  ifu_qed_instruction, exec_dup, stall,
    output qed_ifu_instruction, qed_vld_out, qed_fifo_count, qed_drained,
           orig_issued, dup_issued
  );
endinterface

`default_nettype wire

// File: rtl/qed_dup_injector.sv
// +--------------------------------------------------------------------------+
// | qed_dup_injector : legalises originals to x0..x15 and replays remapped   |
// | duplicates (x17..x31) from a FIFO.                      Rev 1.0          |
// +--------------------------------------------------------------------------+
`default_nettype none

module qed_dup_injector #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int CNT_W = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  qed_dup_injector_if.slave  bus
);

  localparam logic [31:0]    c_NOP    = 32'h0000_0013;
  localparam logic [6:0]     c_OP     = 7'b0110011;
  localparam logic [6:0]     c_OP_IMM = 7'b0010011;
  localparam logic [6:0]     c_LUI    = 7'b0110111;
  localparam logic [PTR_W:0] c_FULL   = (PTR_W+1)'(DEPTH);

  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [31:0]      r_out;
  logic             r_vld;
  logic [CNT_W-1:0] r_orig_cnt;
  logic [CNT_W-1:0] r_dup_cnt;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_bad;
  logic        w_chk_rs1;
  logic        w_chk_rs2;
  logic [31:0] w_legal;
  logic [31:0] w_dup;
  logic        w_dup_mode;
  logic        w_push;
  logic        w_pop;

  // Legalisation and remap; rs2 of OP-IMM is immediate and left alone.
  always_comb begin
    w_opcode  = bus.ifu_qed_instruction[6:0];
    w_rd      = bus.ifu_qed_instruction[11:7];
    w_rs1     = bus.ifu_qed_instruction[19:15];
    w_rs2     = bus.ifu_qed_instruction[24:20];
    w_bad     = 1'b1;
    w_chk_rs1 = 1'b0;
    w_chk_rs2 = 1'b0;
    case (w_opcode)
      c_OP: begin
        w_bad     = w_rd[4] | w_rs1[4] | w_rs2[4];
        w_chk_rs1 = 1'b1;
        w_chk_rs2 = 1'b1;
      end
      c_OP_IMM: begin
        w_bad     = w_rd[4] | w_rs1[4];
        w_chk_rs1 = 1'b1;
      end
      c_LUI:   w_bad = w_rd[4];
      default: w_bad = 1'b1;
    endcase

    w_legal = w_bad ? c_NOP : bus.ifu_qed_instruction;
    w_dup   = w_legal;
    if (w_legal[11:7] != 5'd0) w_dup[11] = 1'b1;
    if (!w_bad && w_chk_rs1 && (w_legal[19:15] != 5'd0)) w_dup[19] = 1'b1;
    if (!w_bad && w_chk_rs2 && (w_legal[24:20] != 5'd0)) w_dup[24] = 1'b1;
  end

  // A full FIFO forces replay, so a push can never overflow.
  assign w_dup_mode = (bus.exec_dup && (r_count != '0)) || (r_count == c_FULL);
  assign w_pop      = !bus.stall && w_dup_mode;
  assign w_push     = !bus.stall && !w_dup_mode && (w_legal[11:7] != 5'd0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dup;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out      <= c_NOP;
      r_vld      <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_orig_cnt <= '0;
      r_dup_cnt  <= '0;
    end else if (!bus.stall) begin
      r_vld <= 1'b1;
      r_out <= w_dup_mode ? r_mem[r_rd_ptr] : w_legal;
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_count    <= r_count + (PTR_W+1)'(1);
        r_orig_cnt <= r_orig_cnt + CNT_W'(1);
      end else if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
        r_count   <= r_count - (PTR_W+1)'(1);
        r_dup_cnt <= r_dup_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.qed_ifu_instruction = r_out;
  assign bus.qed_vld_out         = r_vld;
  assign bus.qed_fifo_count      = r_count;
  assign bus.qed_drained         = (r_count == '0);
  assign bus.orig_issued         = r_orig_cnt;
  assign bus.dup_issued          = r_dup_cnt;

endmodule

`default_nettype wire

// File: tb/tb_qed_dup_injector.sv
// Directed bench for qed_dup_injector: hand-computed expectations checked
// with immediate assertions one cycle after each drive.
`default_nettype none

module tb_qed_dup_injector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  qed_dup_injector_if #(.PTR_W(4), .CNT_W(16)) bus ();

  qed_dup_injector #(.DEPTH(16), .PTR_W(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, cross the edge, settle.
  task automatic step(input logic [31:0] ins, input logic ed, input logic st);
    bus.ifu_qed_instruction = ins;
    bus.exec_dup            = ed;
    bus.stall               = st;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] out, input int cnt,
                           input int orig, input int dup);
    chk({tag, "_out"},  bus.qed_ifu_instruction, out);
    chk({tag, "_cnt"},  32'(bus.qed_fifo_count), 32'(cnt));
    chk({tag, "_orig"}, 32'(bus.orig_issued), 32'(orig));
    chk({tag, "_dup"},  32'(bus.dup_issued), 32'(dup));
    chk({tag, "_drn"},  32'(bus.qed_drained), 32'(cnt == 0));
    chk({tag, "_inv"},  32'(16'(bus.orig_issued - bus.dup_issued)), 32'(cnt));
  endtask

  initial begin
    bus.ifu_qed_instruction = 32'h0051_0093;
    bus.exec_dup = 1'b0;
    bus.stall    = 1'b0;
    rst = 1'b1;
    step(32'h0051_0093, 1'b0, 1'b0);
    step(32'h0051_0093, 1'b0, 1'b0);
    chk_state("reset", 32'h0000_0013, 0, 0, 0);
    chk("reset_vld", 32'(bus.qed_vld_out), 32'd0);
    rst = 1'b0;

    // ADDI x1,x2,5 then its duplicate
    step(32'h0051_0093, 1'b0, 1'b0);
    chk_state("addi", 32'h0051_0093, 1, 1, 0);
    chk("addi_vld", 32'(bus.qed_vld_out), 32'd1);
    step(32'h0051_0093, 1'b1, 1'b0);
    chk_state("addi_dup", 32'h0059_0893, 0, 1, 1);

    // ADD x3,x1,x2: all three fields remapped
    step(32'h0020_81B3, 1'b0, 1'b0);
    chk_state("add", 32'h0020_81B3, 1, 2, 1);
    step(32'h0020_81B3, 1'b1, 1'b0);
    chk_state("add_dup", 32'h0128_89B3, 0, 2, 2);

    // x0 source preserved; LUI immediate untouched
    step(32'h0070_0093, 1'b0, 1'b0);
    chk_state("addi_x0", 32'h0070_0093, 1, 3, 2);
    step(32'h1234_52B7, 1'b0, 1'b0);
    chk_state("lui", 32'h1234_52B7, 2, 4, 2);
    step(32'h0000_0000, 1'b1, 1'b0);
    chk_state("addi_x0_dup", 32'h0070_0893, 1, 4, 3);
    step(32'h0000_0000, 1'b1, 1'b0);
    chk_state("lui_dup", 32'h1234_5AB7, 0, 4, 4);

    // Illegal originals become NOP with no push
    step(32'h0051_0893, 1'b0, 1'b0);
    chk_state("ill_rd17", 32'h0000_0013, 0, 4, 4);
    step(32'h0001_2083, 1'b0, 1'b0);
    chk_state("ill_lw", 32'h0000_0013, 0, 4, 4);
    step(32'h0110_81B3, 1'b0, 1'b0);
    chk_state("ill_rs2", 32'h0000_0013, 0, 4, 4);
    // rd=x0 legal but not duplicated; OP-IMM imm bit 24 is not a register
    step(32'h0050_0013, 1'b0, 1'b0);
    chk_state("rd_x0", 32'h0050_0013, 0, 4, 4);
    step(32'h0100_0093, 1'b0, 1'b0);
    chk_state("imm_b24", 32'h0100_0093, 1, 5, 4);
    step(32'h0000_0000, 1'b1, 1'b0);
    chk_state("imm_b24_dup", 32'h0100_0893, 0, 5, 5);

    // exec_dup on an empty FIFO falls back to originals
    step(32'h0051_0093, 1'b1, 1'b0);
    chk_state("empty_dup", 32'h0051_0093, 1, 6, 5);
    step(32'h0000_0000, 1'b1, 1'b0);
    chk_state("empty_dup_pop", 32'h0059_0893, 0, 6, 6);

    // Fill to DEPTH, then a full FIFO forces replay
    for (int i = 1; i <= 16; i++) begin
      step(32'h0000_0093 | (32'(i) << 20), 1'b0, 1'b0);
      chk("fill_out", bus.qed_ifu_instruction, 32'h0000_0093 | (32'(i) << 20));
    end
    chk_state("full", 32'h0100_0093, 16, 22, 6);
    step(32'h0051_0093, 1'b0, 1'b0);
    chk_state("forced", 32'h0010_0893, 15, 22, 7);
    for (int i = 2; i <= 16; i++) begin
      step(32'h0051_0093, 1'b1, 1'b0);
      chk("drain_out", bus.qed_ifu_instruction, 32'h0000_0893 | (32'(i) << 20));
    end
    chk_state("drained", 32'h0100_0893, 0, 22, 22);

    // Stall freezes output, FIFO and counters
    step(32'h0051_0093, 1'b0, 1'b0);
    step(32'h0020_81B3, 1'b0, 1'b0);
    chk_state("pre_stall", 32'h0020_81B3, 2, 24, 22);
    step(32'h0070_0093, 1'b1, 1'b1);
    chk_state("stall1", 32'h0020_81B3, 2, 24, 22);
    step(32'h1234_52B7, 1'b0, 1'b1);
    chk_state("stall2", 32'h0020_81B3, 2, 24, 22);
    step(32'h0000_0093, 1'b1, 1'b1);
    chk_state("stall3", 32'h0020_81B3, 2, 24, 22);
    chk("stall_vld", 32'(bus.qed_vld_out), 32'd1);
    step(32'h0000_0000, 1'b1, 1'b0);
    chk_state("post_stall", 32'h0059_0893, 1, 24, 23);

    // Reset mid-operation flushes pending duplicates
    for (int i = 0; i < 4; i++) step(32'h0070_0093, 1'b0, 1'b0);
    chk_state("pre_rst", 32'h0070_0093, 5, 28, 23);
    rst = 1'b1;
    step(32'h0070_0093, 1'b0, 1'b0);
    chk_state("mid_rst", 32'h0000_0013, 0, 0, 0);
    chk("mid_rst_vld", 32'(bus.qed_vld_out), 32'd0);
    rst = 1'b0;
    step(32'h0000_0000, 1'b1, 1'b0);
    chk_state("post_rst", 32'h0000_0013, 0, 0, 0);
    chk("post_rst_vld", 32'(bus.qed_vld_out), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
